// File: rtl/ofmap_writer_pkg.sv
// Shared defaults and FSM encoding for the output feature-map write stage.
package ofmap_writer_pkg;

  localparam int unsigned DEF_DATA_WIDTH = 16;
  localparam int unsigned DEF_ACC_WIDTH  = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    LAST = 2'd2
  } state_t;

endpackage

// File: rtl/ofmap_writer_requant_sat.sv
// Combinational requantizer: round-half-up shift, optional ReLU, saturate to DATA_WIDTH.
module requant_sat #(
  parameter int unsigned ACC_WIDTH  = 32,
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned SHIFT      = 8,
  parameter int unsigned RELU_EN    = 1
) (
  input  logic signed [ACC_WIDTH-1:0]  acc,
  output logic signed [DATA_WIDTH-1:0] q_c,
  output logic                         sat_c
);

  // One guard bit keeps acc + rounding constant from overflowing.
  localparam int unsigned EW = ACC_WIDTH + 1;
  localparam logic signed [EW-1:0] RND     = signed'((EW'(1) << SHIFT) >> 1);
  localparam logic signed [EW-1:0] SAT_MAX =
    signed'(EW'((longint'(1) <<< (DATA_WIDTH - 1)) - longint'(1)));
  localparam logic signed [EW-1:0] SAT_MIN = ~SAT_MAX;

  logic signed [EW-1:0] ext;
  logic signed [EW-1:0] rnd;
  logic signed [EW-1:0] shf;
  logic signed [EW-1:0] rel;
  logic signed [EW-1:0] clip;

  always_comb begin
    ext   = {acc[ACC_WIDTH-1], acc};
    rnd   = ext + RND;
    shf   = rnd >>> SHIFT;
    rel   = ((RELU_EN != 0) && shf[EW-1]) ? '0 : shf;
    clip  = rel;
    sat_c = 1'b0;
    if (rel > SAT_MAX) begin
      clip  = SAT_MAX;
      sat_c = 1'b1;
    end else if (rel < SAT_MIN) begin
      clip  = SAT_MIN;
      sat_c = 1'b1;
    end
    q_c = DATA_WIDTH'(clip);
  end

endmodule

// File: rtl/ofmap_writer.sv
// Output write stage: accepts accumulator words, requantizes, writes one DEPTH-word map per start.
module ofmap_writer
  import ofmap_writer_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned ACC_WIDTH  = DEF_ACC_WIDTH,
  parameter int unsigned SHIFT      = 8,
  parameter int unsigned RELU_EN    = 1,
  parameter int unsigned DEPTH      = 256
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic signed [ACC_WIDTH-1:0]   in_data,
  output logic                          mem_we,
  output logic [$clog2(DEPTH)-1:0]      mem_addr,
  output logic signed [DATA_WIDTH-1:0]  mem_din,
  output logic                          busy,
  output logic                          done,
  output logic                          sat_flag
);

  localparam int unsigned AW = $clog2(DEPTH);

  state_t                        state;
  logic [AW-1:0]                 cnt;
  logic signed [DATA_WIDTH-1:0]  q_c;
  logic                          sat_c;

  requant_sat #(
    .ACC_WIDTH  (ACC_WIDTH),
    .DATA_WIDTH (DATA_WIDTH),
    .SHIFT      (SHIFT),
    .RELU_EN    (RELU_EN)
  ) u_requant (
    .acc   (in_data),
    .q_c   (q_c),
    .sat_c (sat_c)
  );

  // Single registered FSM; in_ready depends only on state so it is set on the transition.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      in_ready <= 1'b0;
      mem_we   <= 1'b0;
      mem_addr <= '0;
      mem_din  <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      sat_flag <= 1'b0;
    end else begin
      mem_we <= 1'b0;
      done   <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state    <= RUN;
            cnt      <= '0;
            sat_flag <= 1'b0;
            in_ready <= 1'b1;
            busy     <= 1'b1;
          end
        end
        RUN: begin
          if (in_valid) begin
            mem_we   <= 1'b1;
            mem_addr <= cnt;
            mem_din  <= q_c;
            sat_flag <= sat_flag | sat_c;
            if (cnt == AW'(DEPTH - 1)) begin
              state    <= LAST;
              in_ready <= 1'b0;
              done     <= 1'b1;
            end else begin
              cnt <= cnt + AW'(1);
            end
          end
        end
        LAST: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state    <= IDLE;
          in_ready <= 1'b0;
          busy     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ofmap_writer.sv
// Directed bench for ofmap_writer: two instances (ReLU on / off), DEPTH=4, DATA_WIDTH=16, SHIFT=8.
module tb_ofmap_writer;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic               a_start, a_valid, a_ready, a_we, a_busy, a_done, a_sat;
  logic signed [31:0] a_data;
  logic [1:0]         a_addr;
  logic signed [15:0] a_din;

  logic               b_start, b_valid, b_ready, b_we, b_busy, b_done, b_sat;
  logic signed [31:0] b_data;
  logic [1:0]         b_addr;
  logic signed [15:0] b_din;

  int checks = 0;
  int errors = 0;

  ofmap_writer #(.DATA_WIDTH(16), .ACC_WIDTH(32), .SHIFT(8), .RELU_EN(1), .DEPTH(4)) dut_a (
    .clk(clk), .rst(rst), .start(a_start), .in_valid(a_valid), .in_ready(a_ready),
    .in_data(a_data), .mem_we(a_we), .mem_addr(a_addr), .mem_din(a_din),
    .busy(a_busy), .done(a_done), .sat_flag(a_sat)
  );

  ofmap_writer #(.DATA_WIDTH(16), .ACC_WIDTH(32), .SHIFT(8), .RELU_EN(0), .DEPTH(4)) dut_b (
    .clk(clk), .rst(rst), .start(b_start), .in_valid(b_valid), .in_ready(b_ready),
    .in_data(b_data), .mem_we(b_we), .mem_addr(b_addr), .mem_din(b_din),
    .busy(b_busy), .done(b_done), .sat_flag(b_sat)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic send_a(input logic signed [31:0] d);
    a_valid = 1'b1; a_data = d;
    tick();
    a_valid = 1'b0;
  endtask

  task automatic send_b(input logic signed [31:0] d);
    b_valid = 1'b1; b_data = d;
    tick();
    b_valid = 1'b0;
  endtask

  task automatic start_a;
    a_start = 1'b1;
    tick();
    a_start = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    checks++; if (a_ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b expected 0", a_ready); end
    checks++; if (a_we !== 1'b0) begin errors++; $display("FAIL reset_we: got %b expected 0", a_we); end
    checks++; if (a_addr !== 2'd0 || a_din !== 16'sd0) begin errors++; $display("FAIL reset_addr_din: got %0d/%0d expected 0/0", a_addr, a_din); end
    checks++; if ({a_busy, a_done, a_sat} !== 3'b000) begin errors++; $display("FAIL reset_flags: got %b expected 000", {a_busy, a_done, a_sat}); end
  endtask

  task automatic test_rounding;
    start_a();
    checks++; if (a_ready !== 1'b1 || a_busy !== 1'b1) begin errors++; $display("FAIL run_entry: got ready=%b busy=%b expected 1/1", a_ready, a_busy); end
    send_a(32'sd384);
    checks++; if (a_we !== 1'b1 || a_addr !== 2'd0 || a_din !== 16'sd2) begin errors++; $display("FAIL round_384: got we=%b addr=%0d din=%0d expected 1/0/2", a_we, a_addr, a_din); end
    send_a(32'sd383);
    checks++; if (a_we !== 1'b1 || a_addr !== 2'd1 || a_din !== 16'sd1) begin errors++; $display("FAIL round_383: got we=%b addr=%0d din=%0d expected 1/1/1", a_we, a_addr, a_din); end
    send_a(-32'sd1000);
    checks++; if (a_addr !== 2'd2 || a_din !== 16'sd0) begin errors++; $display("FAIL relu_on: got addr=%0d din=%0d expected 2/0", a_addr, a_din); end
    send_a(32'sd100);
    checks++; if (a_done !== 1'b1 || a_addr !== 2'd3 || a_din !== 16'sd0 || a_ready !== 1'b0) begin errors++; $display("FAIL last_word: got done=%b addr=%0d din=%0d ready=%b expected 1/3/0/0", a_done, a_addr, a_din, a_ready); end
    checks++; if (a_sat !== 1'b0) begin errors++; $display("FAIL no_sat: got %b expected 0", a_sat); end
    tick();
    checks++; if ({a_done, a_we, a_busy, a_ready} !== 4'b0000) begin errors++; $display("FAIL after_done: got %b expected 0000", {a_done, a_we, a_busy, a_ready}); end
  endtask

  task automatic test_relu_off;
    b_start = 1'b1; tick(); b_start = 1'b0;
    send_b(-32'sd1000);
    checks++; if (b_we !== 1'b1 || b_din !== -16'sd4 || b_sat !== 1'b0) begin errors++; $display("FAIL relu_off: got we=%b din=%0d sat=%b expected 1/-4/0", b_we, b_din, b_sat); end
    send_b(-32'sd16777216);
    checks++; if (b_din !== -16'sd32768 || b_sat !== 1'b1) begin errors++; $display("FAIL neg_sat: got din=%0d sat=%b expected -32768/1", b_din, b_sat); end
    send_b(32'sd0);
    send_b(32'sd0);
    checks++; if (b_done !== 1'b1 || b_sat !== 1'b1) begin errors++; $display("FAIL b_done_sticky: got done=%b sat=%b expected 1/1", b_done, b_sat); end
    tick();
    b_start = 1'b1; tick(); b_start = 1'b0;
    checks++; if (b_sat !== 1'b0 || b_busy !== 1'b1) begin errors++; $display("FAIL b_sat_clear: got sat=%b busy=%b expected 0/1", b_sat, b_busy); end
  endtask

  task automatic test_saturation;
    start_a();
    send_a(32'sd16777216);
    checks++; if (a_din !== 16'sd32767 || a_sat !== 1'b1) begin errors++; $display("FAIL pos_sat: got din=%0d sat=%b expected 32767/1", a_din, a_sat); end
    send_a(32'sd0);
    send_a(32'sd0);
    send_a(32'sd0);
    checks++; if (a_sat !== 1'b1 || a_done !== 1'b1) begin errors++; $display("FAIL sat_sticky: got sat=%b done=%b expected 1/1", a_sat, a_done); end
    tick();
    start_a();
    checks++; if (a_sat !== 1'b0) begin errors++; $display("FAIL sat_clear: got %b expected 0", a_sat); end
    // Finish this frame so dut_a is back in IDLE.
    for (int i = 0; i < 4; i++) send_a(32'sd0);
    tick();
  endtask

  task automatic test_gaps;
    logic pat [6] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    int k = 0;
    start_a();
    for (int i = 0; i < 6; i++) begin
      a_valid = pat[i];
      a_data  = 32'(256 * (k + 1));
      tick();
      checks++; if (a_we !== pat[i]) begin errors++; $display("FAIL gap_we[%0d]: got %b expected %b", i, a_we, pat[i]); end
      if (pat[i]) begin
        checks++; if (a_addr !== 2'(k) || a_din !== 16'(k + 1)) begin errors++; $display("FAIL gap_write[%0d]: got addr=%0d din=%0d expected %0d/%0d", i, a_addr, a_din, k, k + 1); end
        k++;
      end
      checks++; if (a_done !== (k == 4 && pat[i])) begin errors++; $display("FAIL gap_done[%0d]: got %b expected %b", i, a_done, (k == 4 && pat[i])); end
    end
    a_valid = 1'b0;
    checks++; if (a_addr !== 2'd3 || a_ready !== 1'b0) begin errors++; $display("FAIL gap_end: got addr=%0d ready=%b expected 3/0", a_addr, a_ready); end
    tick();
    checks++; if (a_ready !== 1'b0 || a_done !== 1'b0) begin errors++; $display("FAIL gap_idle: got ready=%b done=%b expected 0/0", a_ready, a_done); end
  endtask

  task automatic test_start_ignored;
    start_a();
    send_a(32'sd2560);
    a_start = 1'b1;
    send_a(32'sd256);
    a_start = 1'b0;
    checks++; if (a_addr !== 2'd1 || a_din !== 16'sd1 || a_busy !== 1'b1) begin errors++; $display("FAIL start_in_run: got addr=%0d din=%0d busy=%b expected 1/1/1", a_addr, a_din, a_busy); end
    send_a(32'sd512);
    send_a(32'sd768);
    checks++; if (a_done !== 1'b1 || a_addr !== 2'd3 || a_din !== 16'sd3) begin errors++; $display("FAIL start_frame_end: got done=%b addr=%0d din=%0d expected 1/3/3", a_done, a_addr, a_din); end
    a_start = 1'b1;
    tick();
    a_start = 1'b0;
    checks++; if (a_busy !== 1'b0 || a_ready !== 1'b0) begin errors++; $display("FAIL start_in_last: got busy=%b ready=%b expected 0/0", a_busy, a_ready); end
  endtask

  task automatic test_reset_mid;
    start_a();
    send_a(32'sd256);
    send_a(32'sd512);
    a_valid = 1'b1; a_data = 32'sd768; rst = 1'b1;
    tick();
    a_valid = 1'b0; rst = 1'b0;
    checks++; if ({a_we, a_done, a_busy, a_ready, a_sat} !== 5'b0 || a_addr !== 2'd0 || a_din !== 16'sd0) begin errors++; $display("FAIL mid_reset: got flags=%b addr=%0d din=%0d expected 00000/0/0", {a_we, a_done, a_busy, a_ready, a_sat}, a_addr, a_din); end
    tick();
    checks++; if (a_done !== 1'b0 || a_we !== 1'b0) begin errors++; $display("FAIL mid_reset_quiet: got done=%b we=%b expected 0/0", a_done, a_we); end
    start_a();
    send_a(32'sd1280);
    checks++; if (a_we !== 1'b1 || a_addr !== 2'd0 || a_din !== 16'sd5) begin errors++; $display("FAIL restart_addr: got we=%b addr=%0d din=%0d expected 1/0/5", a_we, a_addr, a_din); end
    rst = 1'b1; a_start = 1'b1;
    tick();
    rst = 1'b0; a_start = 1'b0;
    checks++; if (a_busy !== 1'b0 || a_ready !== 1'b0) begin errors++; $display("FAIL rst_beats_start: got busy=%b ready=%b expected 0/0", a_busy, a_ready); end
  endtask

  initial begin
    rst = 1'b1;
    a_start = 1'b0; a_valid = 1'b0; a_data = '0;
    b_start = 1'b0; b_valid = 1'b0; b_data = '0;
    test_reset();
    test_rounding();
    test_relu_off();
    test_saturation();
    test_gaps();
    test_start_ignored();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
